// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues one registered memory request per aligned
// load/store, stalls the pipeline while it is outstanding, and times out after 256 cycles.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byteen,
  output logic        stall,
  output logic        done,
  output logic [31:0] ld_rdata,
  output logic [31:0] ld_addr,
  output logic [2:0]  ld_op,
  output logic        bus_err,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam logic [2:0] DM_HALFWORD = 3'd1;
  localparam logic [2:0] DM_BYTE     = 3'd2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_reg;
  logic [7:0]  wait_cnt_reg;
  logic        is_half;
  logic        is_byte;
  logic        misaligned;
  logic        accept;
  logic [3:0]  byteen_next;
  logic [31:0] wdata_next;

  // Unknown width codes fall through to word behaviour.
  assign is_half    = (req_op == DM_HALFWORD);
  assign is_byte    = (req_op == DM_BYTE);
  assign misaligned = is_half ? req_addr[0] : (!is_byte && (req_addr[1:0] != 2'b00));
  assign accept     = (state_reg == IDLE) && req_valid && !misaligned;

  assign stall    = accept || (state_reg == BUSY);
  assign exc_adel = (state_reg == IDLE) && req_valid && misaligned && !req_we;
  assign exc_ades = (state_reg == IDLE) && req_valid && misaligned &&  req_we;

  // Per-lane store data replication and byte enables.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_next[gi*8 +: 8] = is_byte ? req_wdata[7:0] :
                                     is_half ? req_wdata[(gi%2)*8 +: 8] :
                                               req_wdata[gi*8 +: 8];
      assign byteen_next[gi] = req_we && (is_byte ? (req_addr[1:0] == 2'(gi)) :
                                          is_half ? (req_addr[1] == 1'(gi/2)) :
                                                    1'b1);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 8'd0;
      m_req        <= 1'b0;
      m_addr       <= 32'd0;
      m_wdata      <= 32'd0;
      m_byteen     <= 4'd0;
      done         <= 1'b0;
      bus_err      <= 1'b0;
      ld_rdata     <= 32'd0;
      ld_addr      <= 32'd0;
      ld_op        <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg    <= BUSY;
            wait_cnt_reg <= 8'd0;
            m_req        <= 1'b1;
            m_addr       <= {req_addr[31:2], 2'b00};
            m_wdata      <= wdata_next;
            m_byteen     <= byteen_next;
            ld_addr      <= req_addr;
            ld_op        <= req_op;
          end
        end
        BUSY: begin
          // An ack arriving together with the final count still completes normally.
          if (m_ack) begin
            state_reg <= RESP;
            m_req     <= 1'b0;
            done      <= 1'b1;
            bus_err   <= 1'b0;
            if (m_byteen == 4'd0) begin
              ld_rdata <= m_rdata;
            end
          end else if (wait_cnt_reg == 8'd255) begin
            state_reg <= RESP;
            m_req     <= 1'b0;
            done      <= 1'b1;
            bus_err   <= 1'b1;
            ld_rdata  <= 32'd0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          bus_err   <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          m_req     <= 1'b0;
          done      <= 1'b0;
          bus_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one task per scenario, inline checks, single summary.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic        stall;
  logic        done;
  logic [31:0] ld_rdata;
  logic [31:0] ld_addr;
  logic [2:0]  ld_op;
  logic        bus_err;
  logic        exc_adel;
  logic        exc_ades;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_byteen(m_byteen),
    .stall(stall), .done(done), .ld_rdata(ld_rdata), .ld_addr(ld_addr), .ld_op(ld_op),
    .bus_err(bus_err), .exc_adel(exc_adel), .exc_ades(exc_ades)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic we, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd);
    req_valid = v; req_we = we; req_op = op; req_addr = a; req_wdata = wd;
  endtask

  task automatic test_reset();
    reset = 1'b0; m_ack = 1'b0; m_rdata = 32'd0;
    drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    tick(); tick();
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req: got %b expected 0", m_req); end
    n_checks++; if (m_addr !== 32'd0) begin n_fail++; $display("FAIL reset_m_addr: got %h expected 0", m_addr); end
    n_checks++; if (m_byteen !== 4'd0) begin n_fail++; $display("FAIL reset_m_byteen: got %b expected 0", m_byteen); end
    n_checks++; if (done !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b expected 00", done, bus_err); end
    n_checks++; if (ld_rdata !== 32'd0 || ld_addr !== 32'd0 || ld_op !== 3'd0) begin n_fail++; $display("FAIL reset_ld: got %h %h %h expected zeros", ld_rdata, ld_addr, ld_op); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    reset = 1'b1;
    tick();
    $display("txn reset: outputs checked");
  endtask

  task automatic test_store_byte();
    drive_req(1'b1, 1'b1, 3'd2, 32'h0000_1003, 32'h0000_00AB);
    #1;
    n_checks++; if (stall !== 1'b1 || exc_ades !== 1'b0) begin n_fail++; $display("FAIL sb_accept: stall=%b ades=%b expected 1 0", stall, exc_ades); end
    tick();
    req_valid = 1'b0;
    #1;
    n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL sb_m_req: got %b expected 1", m_req); end
    n_checks++; if (m_byteen !== 4'b1000) begin n_fail++; $display("FAIL sb_byteen: got %b expected 1000", m_byteen); end
    n_checks++; if (m_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata: got %h expected ababab ab", m_wdata); end
    n_checks++; if (m_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr: got %h expected 00001000", m_addr); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sb_busy_stall: got %b expected 1", stall); end
    tick();
    m_ack = 1'b1; m_rdata = 32'h5555_AAAA;
    #1;
    n_checks++; if (m_req !== 1'b1 || m_byteen !== 4'b1000 || done !== 1'b0) begin n_fail++; $display("FAIL sb_busy_hold: m_req=%b byteen=%b done=%b expected 1 1000 0", m_req, m_byteen, done); end
    tick();
    m_ack = 1'b0;
    #1;
    n_checks++; if (done !== 1'b1 || bus_err !== 1'b0) begin n_fail++; $display("FAIL sb_done: done=%b err=%b expected 1 0", done, bus_err); end
    n_checks++; if (stall !== 1'b0 || m_req !== 1'b0) begin n_fail++; $display("FAIL sb_resp: stall=%b m_req=%b expected 0 0", stall, m_req); end
    n_checks++; if (ld_rdata !== 32'd0) begin n_fail++; $display("FAIL sb_ld_rdata_kept: got %h expected 0", ld_rdata); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL sb_done_pulse: got %b expected 0", done); end
    $display("txn store byte addr=00001003 byteen=%b wdata=%h", m_byteen, m_wdata);
  endtask

  task automatic test_load_half();
    drive_req(1'b1, 1'b0, 3'd1, 32'h0000_2002, 32'h0);
    tick();
    req_valid = 1'b0; m_ack = 1'b1; m_rdata = 32'h8765_4321;
    #1;
    n_checks++; if (m_req !== 1'b1 || m_byteen !== 4'b0000) begin n_fail++; $display("FAIL lh_busy: m_req=%b byteen=%b expected 1 0000", m_req, m_byteen); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL lh_early_done: got %b expected 0", done); end
    tick();
    m_ack = 1'b0; m_rdata = 32'h0;
    #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL lh_latency: done=%b expected 1", done); end
    n_checks++; if (ld_rdata !== 32'h8765_4321) begin n_fail++; $display("FAIL lh_rdata: got %h expected 87654321", ld_rdata); end
    n_checks++; if (ld_addr !== 32'h0000_2002 || ld_op !== 3'd1) begin n_fail++; $display("FAIL lh_ld_info: got %h %0d expected 00002002 1", ld_addr, ld_op); end
    tick();
    $display("txn load half addr=00002002 rdata=%h", ld_rdata);
  endtask

  task automatic test_misaligned();
    drive_req(1'b1, 1'b0, 3'd0, 32'h0000_0006, 32'h0);
    #1;
    n_checks++; if (exc_adel !== 1'b1 || exc_ades !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL lw_mis: adel=%b ades=%b stall=%b expected 1 0 0", exc_adel, exc_ades, stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (m_req !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL lw_mis_noreq: m_req=%b done=%b expected 0 0", m_req, done); end
    end
    drive_req(1'b1, 1'b1, 3'd1, 32'h0000_0011, 32'h0);
    #1;
    n_checks++; if (exc_ades !== 1'b1 || exc_adel !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL sh_mis: ades=%b adel=%b stall=%b expected 1 0 0", exc_ades, exc_adel, stall); end
    drive_req(1'b1, 1'b0, 3'd5, 32'h0000_0002, 32'h0);
    #1;
    n_checks++; if (exc_adel !== 1'b1) begin n_fail++; $display("FAIL op5_as_word: adel=%b expected 1", exc_adel); end
    req_valid = 1'b0;
    tick();
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL mis_final: m_req=%b expected 0", m_req); end
    $display("txn misaligned accesses rejected");
  endtask

  task automatic test_timeout();
    int cycles;
    drive_req(1'b1, 1'b1, 3'd0, 32'h0000_0040, 32'h1234_5678);
    tick();
    req_valid = 1'b0;
    #1;
    n_checks++; if (m_byteen !== 4'b1111 || m_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL to_word: byteen=%b wdata=%h expected 1111 12345678", m_byteen, m_wdata); end
    cycles = 0;
    while (stall === 1'b1 && cycles < 300) begin
      cycles++;
      tick();
    end
    n_checks++; if (cycles !== 256) begin n_fail++; $display("FAIL to_cycles: got %0d expected 256", cycles); end
    n_checks++; if (done !== 1'b1 || bus_err !== 1'b1 || m_req !== 1'b0) begin n_fail++; $display("FAIL to_resp: done=%b err=%b m_req=%b expected 1 1 0", done, bus_err, m_req); end
    n_checks++; if (ld_rdata !== 32'd0) begin n_fail++; $display("FAIL to_rdata: got %h expected 0", ld_rdata); end
    tick();
    n_checks++; if (bus_err !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL to_clear: err=%b done=%b expected 0 0", bus_err, done); end
    $display("txn store word timeout after %0d busy cycles", cycles);
  endtask

  task automatic test_ack_at_limit();
    drive_req(1'b1, 1'b0, 3'd0, 32'h0000_0080, 32'h0);
    tick();
    req_valid = 1'b0;
    repeat (255) tick();
    n_checks++; if (stall !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL lim_busy: stall=%b done=%b expected 1 0", stall, done); end
    m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
    tick();
    m_ack = 1'b0; m_rdata = 32'h0;
    #1;
    n_checks++; if (done !== 1'b1 || bus_err !== 1'b0) begin n_fail++; $display("FAIL lim_ack_wins: done=%b err=%b expected 1 0", done, bus_err); end
    n_checks++; if (ld_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lim_rdata: got %h expected cafef00d", ld_rdata); end
    tick();
    $display("txn load word ack at final count rdata=%h", ld_rdata);
  endtask

  task automatic test_reset_mid_busy();
    drive_req(1'b1, 1'b0, 3'd0, 32'h0000_00C0, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (m_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid: m_req=%b stall=%b expected 0 0", m_req, stall); end
    #1;
    reset = 1'b1;
    tick();
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      m_ack = 1'b0;
      n_checks++; if (done !== 1'b0 || m_req !== 1'b0 || ld_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_late_ack: done=%b m_req=%b rdata=%h expected 0 0 0", done, m_req, ld_rdata); end
    end
    $display("txn reset during busy discarded");
  endtask

  task automatic test_back_to_back();
    drive_req(1'b1, 1'b0, 3'd0, 32'h0000_0100, 32'h0);
    tick();
    m_ack = 1'b1; m_rdata = 32'h1111_1111;
    tick();
    m_ack = 1'b0; m_rdata = 32'h0;
    drive_req(1'b1, 1'b0, 3'd0, 32'h0000_0104, 32'h0);
    #1;
    n_checks++; if (done !== 1'b1 || stall !== 1'b0 || ld_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_first: done=%b stall=%b rdata=%h expected 1 0 11111111", done, stall, ld_rdata); end
    tick();
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (stall !== 1'b1 || m_req !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: stall=%b m_req=%b done=%b expected 1 0 0", stall, m_req, done); end
    tick();
    req_valid = 1'b0; m_ack = 1'b0; m_rdata = 32'h2222_2222;
    #1;
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h0000_0104 || ld_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_busy: m_req=%b addr=%h rdata=%h expected 1 00000104 11111111", m_req, m_addr, ld_rdata); end
    tick();
    m_ack = 1'b1; m_rdata = 32'h3333_3333;
    tick();
    m_ack = 1'b0; m_rdata = 32'h0;
    #1;
    n_checks++; if (done !== 1'b1 || ld_rdata !== 32'h3333_3333 || ld_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL b2b_second: done=%b rdata=%h addr=%h expected 1 33333333 00000104", done, ld_rdata, ld_addr); end
    tick();
    $display("txn back-to-back loads rdata=%h", ld_rdata);
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
